// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider retiring one quotient bit per cycle.
// Signed operands are divided as magnitudes; signs are reapplied in FIXUP.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             dvd_neg;
    logic             dvs_neg;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];

    // The dividend register doubles as the quotient accumulator: its MSB shifts
    // into the partial remainder while the new quotient bit enters at the LSB.
    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        remo_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = DIVIDE;
                        dvd_d   = dvd_neg ? -dividend : dividend;
                        dvs_d   = dvs_neg ? -divisor : divisor;
                        q_neg_d = dvd_neg ^ dvs_neg;
                        r_neg_d = dvd_neg;
                        cnt_d   = CW'(WIDTH);
                        rem_d   = '0;
                    end
                end
            end
            DIVIDE: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quot_d  = q_neg_q ? -dvd_q : dvd_q;
                remo_d  = r_neg_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d == DIVIDE) || (state_d == FIXUP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an
// arithmetic reference model that tracks expected outputs every cycle.
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Model state: cycle index, pending result and the cycle it must appear in.
    int               cyc = 0;
    bit               running = 1'b0;
    int               done_cyc = 0;
    logic [WIDTH-1:0] pend_q, pend_r;
    logic             pend_dbz;
    logic [WIDTH-1:0] exp_q = '0;
    logic [WIDTH-1:0] exp_r = '0;
    logic             exp_dbz = 1'b0;
    logic             exp_busy = 1'b0;
    logic             exp_done = 1'b0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division, 64-bit signed for the signed case.
    always @(posedge clk) begin
        longint sa, sb, qq, rr;
        int     lat;
        if (rst) begin
            running  = 1'b0;
            exp_q    = '0;
            exp_r    = '0;
            exp_dbz  = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (running && cyc == done_cyc) begin
                running = 1'b0;
            end else if (!running && start) begin
                lat = WIDTH + 2;
                if (divisor == '0) begin
                    pend_q   = '1;
                    pend_r   = dividend;
                    pend_dbz = 1'b1;
                    lat      = 1;
                end else if (is_signed) begin
                    sa       = longint'($signed(dividend));
                    sb       = longint'($signed(divisor));
                    qq       = sa / sb;
                    rr       = sa % sb;
                    pend_q   = qq[WIDTH-1:0];
                    pend_r   = rr[WIDTH-1:0];
                    pend_dbz = 1'b0;
                end else begin
                    pend_q   = dividend / divisor;
                    pend_r   = dividend % divisor;
                    pend_dbz = 1'b0;
                end
                done_cyc = cyc + lat;
                running  = 1'b1;
                exp_dbz  = 1'b0;
            end
            if (running && cyc + 1 == done_cyc) begin
                exp_q   = pend_q;
                exp_r   = pend_r;
                exp_dbz = pend_dbz;
            end
            exp_busy = running && (cyc + 1 < done_cyc);
            exp_done = running && (cyc + 1 == done_cyc);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("busy", WIDTH'(busy), WIDTH'(exp_busy));
            checkOutput("done", WIDTH'(done), WIDTH'(exp_done));
            checkOutput("quotient", quotient, exp_q);
            checkOutput("remainder", remainder, exp_r);
            checkOutput("div_by_zero", WIDTH'(div_by_zero), WIDTH'(exp_dbz));
            checkOutput("busy_and_done", WIDTH'(busy & done), '0);
        end
    end

    // Called at a negedge; holds start for one cycle and returns at the next negedge.
    task automatic applyStimulus(input logic sg, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, output int t0);
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        t0        = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int dc);
        bit seen = 1'b0;
        dc = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                dc   = cyc;
            end else begin
                @(negedge clk);
            end
        end
        checkOutput("done_timeout", WIDTH'(seen), WIDTH'(1));
    endtask

    task automatic runDirected(input string name, input logic sg,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input int lat, input logic [WIDTH-1:0] eq,
                               input logic [WIDTH-1:0] er, input logic edbz);
        int t0, dc;
        applyStimulus(sg, a, b, t0);
        waitDone(dc);
        checkOutput({name, "_latency"}, WIDTH'(dc - t0), WIDTH'(lat));
        checkOutput({name, "_q"}, quotient, eq);
        checkOutput({name, "_r"}, remainder, er);
        checkOutput({name, "_dbz"}, WIDTH'(div_by_zero), WIDTH'(edbz));
        @(negedge clk);
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = WIDTH'($urandom_range(0, 100));
            5:       v = -WIDTH'($urandom_range(1, 100));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int t0, dc;
        bit saw_done;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        checkOutput("reset_busy", WIDTH'(busy), '0);
        checkOutput("reset_done", WIDTH'(done), '0);
        checkOutput("reset_q", quotient, '0);
        checkOutput("reset_r", remainder, '0);
        checkOutput("reset_dbz", WIDTH'(div_by_zero), '0);
        rst = 1'b0;
        @(negedge clk);

        runDirected("u100_7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0);
        runDirected("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        runDirected("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);
        runDirected("u_dbz", 1'b0, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234, 1'b1);
        runDirected("s_dbz", 1'b1, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234, 1'b1);

        applyStimulus(1'b0, 32'd9, 32'd3, t0);
        checkOutput("dbz_cleared", WIDTH'(div_by_zero), '0);
        waitDone(dc);
        checkOutput("u9_3_q", quotient, 32'd3);
        @(negedge clk);

        runDirected("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 1'b0);
        runDirected("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // Start pulse while busy is ignored; a start right after done is accepted.
        applyStimulus(1'b0, 32'd100, 32'd7, t0);
        repeat (4) @(negedge clk);
        is_signed = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(dc);
        checkOutput("ignore_latency", WIDTH'(dc - t0), WIDTH'(34));
        checkOutput("ignore_q", quotient, 32'd14);
        checkOutput("ignore_r", remainder, 32'd2);
        @(negedge clk);
        checkOutput("b2b_slot", WIDTH'(cyc - t0), WIDTH'(35));
        applyStimulus(1'b0, 32'd9, 32'd3, t0);
        waitDone(dc);
        checkOutput("b2b_latency", WIDTH'(dc - t0), WIDTH'(34));
        checkOutput("b2b_q", quotient, 32'd3);
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        applyStimulus(1'b0, 32'd100, 32'd7, t0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", WIDTH'(busy), '0);
        checkOutput("abort_q", quotient, '0);
        checkOutput("abort_r", remainder, '0);
        saw_done = 1'b0;
        repeat (40) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort_no_done", WIDTH'(saw_done), '0);
        runDirected("after_abort", 1'b0, 32'd9, 32'd3, 34, 32'd3, 32'd0, 1'b0);

        for (int i = 0; i < 40000; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            is_signed = 1'($urandom_range(0, 1));
            dividend  = pickOperand();
            divisor   = pickOperand();
            rst       = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
